// File: rtl/tail_light_scheduler.sv
// Tail-light sequencer/arbiter: arbitrates left, right and hazard requests,
// paces each lamp step with a prescaler and drives six lamps from a Moore FSM.
// The lamp outputs, busy and done are decoded from registered state only.
module tail_light_scheduler #(
    parameter int TICK_DIV = 4,
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    output logic             la,
    output logic             lb,
    output logic             lc,
    output logic             ra,
    output logic             rb,
    output logic             rc,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dbg_state_o,  // current FSM state
    output logic [CNT_W-1:0] dbg_cnt_o     // current prescaler count
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_L1     = 4'd1;
    localparam logic [3:0] S_L2     = 4'd2;
    localparam logic [3:0] S_L3     = 4'd3;
    localparam logic [3:0] S_R1     = 4'd4;
    localparam logic [3:0] S_R2     = 4'd5;
    localparam logic [3:0] S_R3     = 4'd6;
    localparam logic [3:0] S_HZ_ON  = 4'd7;
    localparam logic [3:0] S_HZ_OFF = 4'd8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             tick;
    logic             hz_req;

    // Both turn requests together are treated as a hazard request.
    assign hz_req = hazard | (left & right);
    assign tick   = (cnt_q == CNT_LAST);

    // Next-state logic: IDLE reacts every cycle, all other states advance on tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hz_req)      state_d = S_HZ_ON;
                else if (left)   state_d = S_L1;
                else if (right)  state_d = S_R1;
            end
            S_L1: if (tick) state_d = hazard ? S_HZ_ON : S_L2;
            S_L2: if (tick) state_d = hazard ? S_HZ_ON : S_L3;
            S_L3: if (tick) state_d = hazard ? S_HZ_ON : S_IDLE;
            S_R1: if (tick) state_d = hazard ? S_HZ_ON : S_R2;
            S_R2: if (tick) state_d = hazard ? S_HZ_ON : S_R3;
            S_R3: if (tick) state_d = hazard ? S_HZ_ON : S_IDLE;
            S_HZ_ON:  if (tick) state_d = S_HZ_OFF;
            S_HZ_OFF: if (tick) state_d = hz_req ? S_HZ_ON : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Prescaler: held at zero in IDLE and cleared whenever the state changes.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((state_q == S_IDLE) || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    // done marks the IDLE cycle entered from the end of a turn sequence.
    always_comb begin
        done_d = ((state_q == S_L3) || (state_q == S_R3)) && (state_d == S_IDLE);
    end

    // State, prescaler and done registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Lamp decode from registered state; left and right only overlap in HZ_ON.
    always_comb begin
        la = 1'b0;
        lb = 1'b0;
        lc = 1'b0;
        ra = 1'b0;
        rb = 1'b0;
        rc = 1'b0;
        case (state_q)
            S_L1: la = 1'b1;
            S_L2: begin la = 1'b1; lb = 1'b1; end
            S_L3: begin la = 1'b1; lb = 1'b1; lc = 1'b1; end
            S_R1: ra = 1'b1;
            S_R2: begin ra = 1'b1; rb = 1'b1; end
            S_R3: begin ra = 1'b1; rb = 1'b1; rc = 1'b1; end
            S_HZ_ON: begin
                la = 1'b1; lb = 1'b1; lc = 1'b1;
                ra = 1'b1; rb = 1'b1; rc = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_tail_light_scheduler.sv
// Directed bench for tail_light_scheduler with TICK_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tail_light_scheduler;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 2;

    logic             clk;
    logic             reset;
    logic             left;
    logic             right;
    logic             hazard;
    logic             la, lb, lc, ra, rb, rc;
    logic             busy;
    logic             done;
    logic [3:0]       dbg_state;
    logic [CNT_W-1:0] dbg_cnt;
    logic [5:0]       lamps;

    int checks;
    int errors;

    tail_light_scheduler #(.TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .left        (left),
        .right       (right),
        .hazard      (hazard),
        .la          (la),
        .lb          (lb),
        .lc          (lc),
        .ra          (ra),
        .rb          (rb),
        .rc          (rc),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state),
        .dbg_cnt_o   (dbg_cnt)
    );

    assign lamps = {la, lb, lc, ra, rb, rc};

    // Clock: period 10, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        errors = errors + 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // Expected lamp pattern for a turn step (0..2), {la,lb,lc,ra,rb,rc}.
    function automatic logic [5:0] turn_pat(input bit is_left, input int step);
        logic [2:0] side;
        side = (step == 0) ? 3'b100 : (step == 1) ? 3'b110 : 3'b111;
        return is_left ? {side, 3'b000} : {3'b000, side};
    endfunction

    task automatic do_reset();
        left   = 1'b0;
        right  = 1'b0;
        hazard = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        left   = 1'b1;
        hazard = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({lamps, busy, done} !== 8'b0) begin
            $display("FAIL reset_outputs: got lamps=%b busy=%b done=%b, expected all 0",
                     lamps, busy, done);
            errors++;
        end
        checks++;
        if (dbg_state !== 4'd0 || dbg_cnt !== '0) begin
            $display("FAIL reset_state: got state=%0d cnt=%0d, expected 0/0", dbg_state, dbg_cnt);
            errors++;
        end
        left   = 1'b0;
        hazard = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (dbg_state !== 4'd0 || dbg_cnt !== '0 || {lamps, busy, done} !== 8'b0) begin
            $display("FAIL idle_hold: got state=%0d cnt=%0d lamps=%b busy=%b done=%b, expected idle",
                     dbg_state, dbg_cnt, lamps, busy, done);
            errors++;
        end
    endtask

    // Left pulse: 12 lit cycles, then one IDLE cycle carrying done.
    task automatic test_left_single();
        logic [5:0] exp_l;
        do_reset();
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_l = turn_pat(1'b1, i / 4);
            checks++;
            if ({lamps, busy, done} !== {exp_l, 2'b10}) begin
                $display("FAIL left_seq[%0d]: got lamps=%b busy=%b done=%b, expected lamps=%b busy=1 done=0",
                         i, lamps, busy, done, exp_l);
                errors++;
            end
            @(negedge clk);
        end
        checks++;
        if ({lamps, busy, done} !== 8'b0000_0001) begin
            $display("FAIL left_done: got lamps=%b busy=%b done=%b, expected lamps=0 busy=0 done=1",
                     lamps, busy, done);
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({lamps, busy, done} !== 8'b0) begin
            $display("FAIL left_done_clear: got lamps=%b busy=%b done=%b, expected all 0",
                     lamps, busy, done);
            errors++;
        end
    endtask

    // Held right: period of 13 cycles (12 lit + 1 dark with done).
    task automatic test_right_held();
        logic [5:0] exp_l;
        logic       exp_busy, exp_done;
        int         pos;
        do_reset();
        right = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            pos = i % 13;
            if (pos < 12) begin
                exp_l = turn_pat(1'b0, pos / 4);
                exp_busy = 1'b1;
                exp_done = 1'b0;
            end else begin
                exp_l = 6'b0;
                exp_busy = 1'b0;
                exp_done = 1'b1;
            end
            checks++;
            if ({lamps, busy, done} !== {exp_l, exp_busy, exp_done}) begin
                $display("FAIL right_held[%0d]: got lamps=%b busy=%b done=%b, expected lamps=%b busy=%b done=%b",
                         i, lamps, busy, done, exp_l, exp_busy, exp_done);
                errors++;
            end
            @(negedge clk);
        end
        right = 1'b0;
    endtask

    // left&right together: 4 on / 4 off repeating; release in HZ_ON ends after one HZ_OFF.
    task automatic test_hazard_both();
        logic [5:0] exp_l;
        logic       exp_busy;
        do_reset();
        left  = 1'b1;
        right = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            if (i < 24) begin
                exp_l = ((i % 8) < 4) ? 6'b111111 : 6'b000000;
                exp_busy = 1'b1;
            end else begin
                exp_l = 6'b0;
                exp_busy = 1'b0;
            end
            checks++;
            if ({lamps, busy, done} !== {exp_l, exp_busy, 1'b0}) begin
                $display("FAIL hazard_both[%0d]: got lamps=%b busy=%b done=%b, expected lamps=%b busy=%b done=0",
                         i, lamps, busy, done, exp_l, exp_busy);
                errors++;
            end
            if (i == 16) begin
                left  = 1'b0;
                right = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Hazard raised during L2: L2 completes, then HZ_ON/HZ_OFF, never a done pulse.
    task automatic test_hazard_preempt();
        logic [5:0] exp_l;
        do_reset();
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) hazard = 1'b1;
            if (i == 10) hazard = 1'b0;
            if (i < 8)       exp_l = turn_pat(1'b1, i / 4);
            else if (i < 12) exp_l = 6'b111111;
            else             exp_l = 6'b000000;
            checks++;
            if ({lamps, busy, done} !== {exp_l, 2'b10}) begin
                $display("FAIL hazard_preempt[%0d]: got lamps=%b busy=%b done=%b, expected lamps=%b busy=1 done=0",
                         i, lamps, busy, done, exp_l);
                errors++;
            end
            @(negedge clk);
        end
        checks++;
        if ({lamps, busy, done} !== 8'b0) begin
            $display("FAIL hazard_preempt_end: got lamps=%b busy=%b done=%b, expected all 0",
                     lamps, busy, done);
            errors++;
        end
    endtask

    // Reset pulse between edges in L3: lamps drop at once, no done afterwards.
    task automatic test_reset_mid();
        do_reset();
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        checks++;
        if (lamps !== 6'b111000) begin
            $display("FAIL reset_mid_pre: got lamps=%b, expected 111000", lamps);
            errors++;
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({lamps, busy, done} !== 8'b0 || dbg_state !== 4'd0 || dbg_cnt !== '0) begin
            $display("FAIL reset_mid_async: got lamps=%b busy=%b done=%b state=%0d cnt=%0d, expected all 0",
                     lamps, busy, done, dbg_state, dbg_cnt);
            errors++;
        end
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({lamps, busy, done} !== 8'b0 || dbg_state !== 4'd0 || dbg_cnt !== '0) begin
                $display("FAIL reset_mid_after[%0d]: got lamps=%b busy=%b done=%b state=%0d cnt=%0d, expected all 0",
                         i, lamps, busy, done, dbg_state, dbg_cnt);
                errors++;
            end
        end
    endtask

    // Left held into L1 then released: the full sequence still runs.
    task automatic test_release_early();
        logic [5:0] exp_l;
        do_reset();
        left = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i == 1) left = 1'b0;
            exp_l = turn_pat(1'b1, i / 4);
            checks++;
            if ({lamps, busy, done} !== {exp_l, 2'b10}) begin
                $display("FAIL release_early[%0d]: got lamps=%b busy=%b done=%b, expected lamps=%b busy=1 done=0",
                         i, lamps, busy, done, exp_l);
                errors++;
            end
            @(negedge clk);
        end
        checks++;
        if ({lamps, busy, done} !== 8'b0000_0001) begin
            $display("FAIL release_early_done: got lamps=%b busy=%b done=%b, expected lamps=0 busy=0 done=1",
                     lamps, busy, done);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        left   = 1'b0;
        right  = 1'b0;
        hazard = 1'b0;
        test_reset();
        test_left_single();
        test_right_held();
        test_hazard_both();
        test_hazard_preempt();
        test_reset_mid();
        test_release_early();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
